// File: rtl/fp_muldiv_ctrl_if.sv
// Handshake/strobe bundle between the FP mul/div control sequencer and its neighbours.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; no buffering.
//
// master : request source / result consumer / datapath side (drives requests, carry, out_ready)
// slave  : fp_muldiv_ctrl (drives in_ready, datapath strobes, result valid)
interface fp_muldiv_ctrl_if #(
  parameter int CNT_W = 5
);
  // request side
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic             in_special;
  logic             flush;
  // datapath control
  logic             exp_en;
  logic             exp_sel;
  logic             mant_start;
  logic             mant_en;
  logic [CNT_W-1:0] step_cnt;
  logic             norm_en;
  logic             round_en;
  logic             round_carry;
  // result side
  logic             out_valid;
  logic             out_ready;
  logic             out_op;
  logic             busy;

  modport master (
    output in_valid, in_op, in_special, flush, round_carry, out_ready,
    input  in_ready, exp_en, exp_sel, mant_start, mant_en, step_cnt,
           norm_en, round_en, out_valid, out_op, busy
  );

  modport slave (
    input  in_valid, in_op, in_special, flush, round_carry, out_ready,
    output in_ready, exp_en, exp_sel, mant_start, mant_en, step_cnt,
           norm_en, round_en, out_valid, out_op, busy
  );
endinterface

// File: rtl/fp_muldiv_ctrl.sv
// Control sequencer for the FP multiply/divide unit: IDLE -> EXP -> MANT -> NORM -> ROUND -> DONE.
// Latency: accept at edge k -> out_valid at edge k+N+3 (N=MUL_LAT mul, MANT_W+2 div), +2 per renormalize, k+1 for specials.
// Backpressure: one op in flight; in_ready only in IDLE; DONE holds out_valid/out_op until out_ready.
//
// Ports: clk, arst (async, active-high) plus the slave side of fp_muldiv_ctrl_if:
//   request  in_valid/in_ready, in_op, in_special, flush
//   datapath exp_en, exp_sel, mant_start, mant_en, step_cnt, norm_en, round_en, round_carry
//   result   out_valid/out_ready, out_op, busy
module fp_muldiv_ctrl #(
  parameter int MANT_W  = 24,
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = $clog2(MANT_W + 3)
) (
  input  logic              clk,
  input  logic              arst,
  fp_muldiv_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXP   = 3'd1,
    S_MANT  = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Last MANT iteration index for each operation.
  localparam logic [CNT_W-1:0] TERM_MUL = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] TERM_DIV = CNT_W'(MANT_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic             renorm_q, renorm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered Moore outputs, decoded from the next-state values so they
  // line up with state_q in the same cycle.
  logic exp_en_q,     exp_en_d;
  logic exp_sel_q,    exp_sel_d;
  logic mant_start_q, mant_start_d;
  logic mant_en_q,    mant_en_d;
  logic norm_en_q,    norm_en_d;
  logic round_en_q,   round_en_d;
  logic out_valid_q,  out_valid_d;
  logic busy_q,       busy_d;

  logic [CNT_W-1:0] term_cnt;

  always_comb begin
    term_cnt = op_q ? TERM_DIV : TERM_MUL;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    renorm_d = renorm_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d     = bus.in_op;
          renorm_d = 1'b0;
          state_d  = bus.in_special ? S_DONE : S_EXP;
        end
      end
      S_EXP: begin
        cnt_d   = '0;
        state_d = S_MANT;
      end
      S_MANT: begin
        if (cnt_q == term_cnt) begin
          // Clear on exit so step_cnt reads 0 outside MANT.
          cnt_d   = '0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_NORM: begin
        state_d = S_ROUND;
      end
      S_ROUND: begin
        // Only one renormalize pass; a carry on the second ROUND is dropped.
        if (bus.round_carry && !renorm_q) begin
          renorm_d = 1'b1;
          state_d  = S_NORM;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides every transition, including accept and handoff.
    if (bus.flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      renorm_d = 1'b0;
    end
  end

  // Output decode from next state.
  always_comb begin
    exp_en_d     = (state_d == S_EXP);
    exp_sel_d    = (state_d != S_IDLE) && op_d;
    mant_en_d    = (state_d == S_MANT);
    mant_start_d = (state_d == S_MANT) && (cnt_d == '0);
    norm_en_d    = (state_d == S_NORM);
    round_en_d   = (state_d == S_ROUND);
    out_valid_d  = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      renorm_q     <= 1'b0;
      cnt_q        <= '0;
      exp_en_q     <= 1'b0;
      exp_sel_q    <= 1'b0;
      mant_start_q <= 1'b0;
      mant_en_q    <= 1'b0;
      norm_en_q    <= 1'b0;
      round_en_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      renorm_q     <= renorm_d;
      cnt_q        <= cnt_d;
      exp_en_q     <= exp_en_d;
      exp_sel_q    <= exp_sel_d;
      mant_start_q <= mant_start_d;
      mant_en_q    <= mant_en_d;
      norm_en_q    <= norm_en_d;
      round_en_q   <= round_en_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  // in_ready is the one output allowed to see an input: flush masks it.
  assign bus.in_ready   = (state_q == S_IDLE) && !bus.flush;
  assign bus.exp_en     = exp_en_q;
  assign bus.exp_sel    = exp_sel_q;
  assign bus.mant_start = mant_start_q;
  assign bus.mant_en    = mant_en_q;
  assign bus.step_cnt   = cnt_q;
  assign bus.norm_en    = norm_en_q;
  assign bus.round_en   = round_en_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_op     = op_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fp_muldiv_ctrl.sv
// Bench for fp_muldiv_ctrl: per-cycle expected-output scoreboard fed from a phase-schedule model.
// Latency: n/a.
// Backpressure: bench drives out_ready holds and flushes; monitor checks every cycle.
module tb_fp_muldiv_ctrl;

  localparam int MANT_W  = 24;
  localparam int MUL_LAT = 2;
  localparam int CNT_W   = 5;

  typedef struct packed {
    logic             exp_en;
    logic             exp_sel;
    logic             mant_en;
    logic             mant_start;
    logic [CNT_W-1:0] step_cnt;
    logic             norm_en;
    logic             round_en;
    logic             out_valid;
    logic             busy;
  } word_t;

  logic clk;
  logic arst;

  fp_muldiv_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fp_muldiv_ctrl #(
    .MANT_W (MANT_W),
    .MUL_LAT(MUL_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output for each upcoming cycle, and the op of each pending result.
  word_t exp_q[$];
  logic  txn_q[$];

  int vectors;
  int miscompares;

  function automatic word_t mk(input logic e, input logic s, input logic m, input logic st,
                               input int cnt, input logic n, input logic r, input logic v,
                               input logic b);
    word_t w;
    w.exp_en     = e;
    w.exp_sel    = s;
    w.mant_en    = m;
    w.mant_start = st;
    w.step_cnt   = CNT_W'(cnt);
    w.norm_en    = n;
    w.round_en   = r;
    w.out_valid  = v;
    w.busy       = b;
    return w;
  endfunction

  // Phase schedule of one accepted operation, starting the cycle after accept.
  function automatic void push_seq(input logic op, input logic sp, input logic carry);
    int n;
    n = op ? (MANT_W + 2) : MUL_LAT;
    if (!sp) begin
      exp_q.push_back(mk(1, op, 0, 0, 0, 0, 0, 0, 1));
      for (int i = 0; i < n; i++)
        exp_q.push_back(mk(0, op, 1, (i == 0), i, 0, 0, 0, 1));
      for (int p = 0; p < (carry ? 2 : 1); p++) begin
        exp_q.push_back(mk(0, op, 0, 0, 0, 1, 0, 0, 1));
        exp_q.push_back(mk(0, op, 0, 0, 0, 0, 1, 0, 1));
      end
    end
    exp_q.push_back(mk(0, op, 0, 0, 0, 0, 0, 1, 1));
    txn_q.push_back(op);
  endfunction

  function automatic word_t sample();
    word_t w;
    w.exp_en     = bus.exp_en;
    w.exp_sel    = bus.exp_sel;
    w.mant_en    = bus.mant_en;
    w.mant_start = bus.mant_start;
    w.step_cnt   = bus.step_cnt;
    w.norm_en    = bus.norm_en;
    w.round_en   = bus.round_en;
    w.out_valid  = bus.out_valid;
    w.busy       = bus.busy;
    return w;
  endfunction

  // Monitor: one comparison per cycle against the scoreboard head.
  always @(negedge clk) begin
    word_t act;
    word_t expw;
    logic  exp_rdy;
    act     = sample();
    expw    = (exp_q.size() > 0) ? exp_q[0] : '0;
    exp_rdy = (exp_q.size() == 0) && !bus.flush;
    vectors++;
    if (act !== expw || bus.in_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t strobes got=%h want=%h in_ready got=%b want=%b",
               $time, act, expw, bus.in_ready, exp_rdy);
    end
    if (expw.out_valid) begin
      vectors++;
      if (txn_q.size() == 0 || bus.out_op !== txn_q[0]) begin
        miscompares++;
        $display("FAIL out_op t=%0t got=%b want=%b", $time, bus.out_op,
                 (txn_q.size() > 0) ? txn_q[0] : 1'bx);
      end
    end
    if (exp_q.size() > 0) begin
      if (!expw.out_valid) begin
        void'(exp_q.pop_front());
      end else if (bus.out_ready && !bus.flush) begin
        void'(exp_q.pop_front());
        if (txn_q.size() > 0) void'(txn_q.pop_front());
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic accept(input logic op, input logic sp, input logic carry);
    int g;
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_special  = sp;
    bus.round_carry = carry;
    #1;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (g == 50) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout got in_ready=0 want 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_special = 1'b0;
    push_seq(op, sp, carry);
  endtask

  task automatic finish(input int hold, input int flush_step, input logic flush_done);
    int n;
    int held;
    n    = 0;
    held = 0;
    bus.out_ready = 1'b0;
    forever begin
      if (flush_step >= 0 && bus.mant_en && int'(bus.step_cnt) == flush_step) begin
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        exp_q.delete();
        txn_q.delete();
        break;
      end
      if (bus.out_valid) begin
        if (held >= hold) begin
          bus.out_ready = 1'b1;
          bus.flush     = flush_done;
          @(posedge clk);
          #1;
          bus.out_ready = 1'b0;
          if (flush_done) begin
            bus.flush = 1'b0;
            exp_q.delete();
            txn_q.delete();
          end
          break;
        end
        held++;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL done_timeout got out_valid=0 want 1 within 200 cycles");
        break;
      end
    end
    bus.round_carry = 1'b0;
  endtask

  task automatic do_op(input logic op, input logic sp, input logic carry, input int hold,
                       input int flush_step, input logic flush_done);
    accept(op, sp, carry);
    finish(hold, flush_step, flush_done);
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (sample() !== '0 || bus.in_ready !== 1'b1 || bus.out_op !== 1'b0) begin
      miscompares++;
      $display("FAIL %s strobes got=%h want=0 in_ready got=%b want=1 out_op got=%b want=0",
               tag, sample(), bus.in_ready, bus.out_op);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic op;
    logic sp;
    int   fs;
    vectors         = 0;
    miscompares     = 0;
    arst            = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_op       = 1'b0;
    bus.in_special  = 1'b0;
    bus.flush       = 1'b0;
    bus.round_carry = 1'b0;
    bus.out_ready   = 1'b0;
    #2;
    check_reset_outputs("reset_values");
    @(posedge clk);
    #3;
    arst = 1'b0;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;

    // Directed cases.
    do_op(0, 0, 0, 0, -1, 0);   // multiply, defaults
    do_op(1, 0, 1, 0, -1, 0);   // divide with carry held: NORM ROUND NORM ROUND
    do_op(1, 1, 0, 7, -1, 0);   // special bypass, 7 cycles of backpressure
    do_op(1, 0, 0, 0, 10, 0);   // flush in divide MANT at step 10
    do_op(0, 0, 0, 0, -1, 0);   // multiply after flush
    do_op(0, 0, 1, 2, -1, 1);   // flush coincident with DONE handoff

    // Flush beats an IDLE accept.
    bus.in_valid = 1'b1;
    bus.in_op    = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Async reset between edges in the middle of a divide.
    accept(1, 0, 0);
    repeat (6) @(posedge clk);
    #3;
    arst = 1'b1;
    exp_q.delete();
    txn_q.delete();
    #1;
    check_reset_outputs("async_reset_mid_op");
    repeat (2) @(posedge clk);
    #3;
    arst = 1'b0;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      op = 1'($urandom_range(0, 1));
      sp = ($urandom_range(0, 5) == 0);
      fs = -1;
      if (!sp && $urandom_range(0, 7) == 0)
        fs = op ? int'($urandom_range(0, MANT_W + 1)) : int'($urandom_range(0, MUL_LAT - 1));
      do_op(op, sp, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), fs,
            ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
